demux_router: RTL

- Registered 1-to-NUM_OUT demultiplexer: the distribution-side counterpart of the team's 2:1 select mux.
- Takes one valid/ready input stream and steers each word to the output lane named by its select field.
- Each lane has a 2-entry buffer, so one lane stalling does not corrupt others. Order is preserved within each lane.
- Sits between a single producer (e.g. writeback/result bus) and multiple consumers in the MIPS datapath experiments.

---
 rtl/demux_router_if.sv | 28 ++
 rtl/demux_router.sv | 122 ++++++++++++
 2 files changed

// File: rtl/demux_router_if.sv
// rtl/demux_router_if.sv - stream bundle between a single producer, the demux router and its lane consumers
interface demux_router_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic                     err_sel;
    logic [7:0]               drop_count;

    // Producer and consumers seen from outside the router
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_sel, drop_count
    );

    // Router side
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_sel, drop_count
    );
endinterface

// File: rtl/demux_router.sv
// rtl/demux_router.sv - registered 1-to-NUM_OUT stream demultiplexer with 2-entry buffer per lane
module demux_router #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    demux_router_if.slave bus_io
);
    typedef enum logic [1:0] {
        LANE_EMPTY = 2'd0,
        LANE_ONE   = 2'd1,
        LANE_TWO   = 2'd2
    } lane_state_e;

    lane_state_e        state_q [NUM_OUT];
    lane_state_e        state_d [NUM_OUT];
    logic [WIDTH-1:0]   head_q  [NUM_OUT];
    logic [WIDTH-1:0]   head_d  [NUM_OUT];
    logic [WIDTH-1:0]   tail_q  [NUM_OUT];
    logic [WIDTH-1:0]   tail_d  [NUM_OUT];
    logic [NUM_OUT-1:0] valid_q;
    logic [NUM_OUT-1:0] valid_d;
    logic               err_q;
    logic               err_d;
    logic [7:0]         drop_q;
    logic [7:0]         drop_d;

    logic [NUM_OUT-1:0] sel_hit;
    logic [NUM_OUT-1:0] lane_full;
    logic [NUM_OUT-1:0] push;
    logic [NUM_OUT-1:0] pop;
    logic               sel_drop;
    logic               ready;
    logic               accept;

    // Decode the target lane; readiness uses registered occupancy only, never out_ready
    always_comb begin
        sel_hit   = '0;
        lane_full = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            sel_hit[i]   = (bus_io.in_sel == SEL_W'(i));
            lane_full[i] = (state_q[i] == LANE_TWO);
        end
        // A select matching no lane is the drop path: always accepted, then discarded
        sel_drop = ~|sel_hit;
        ready    = sel_drop | (|(sel_hit & ~lane_full));
        accept   = bus_io.in_valid & ready;
        push     = {NUM_OUT{accept}} & sel_hit;
        pop      = valid_q & bus_io.out_ready;
    end

    // Per-lane occupancy machine plus head/tail data movement and drop accounting
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            case (state_q[i])
                LANE_EMPTY: begin
                    if (push[i]) begin
                        head_d[i]  = bus_io.in_data;
                        state_d[i] = LANE_ONE;
                    end
                end
                LANE_ONE: begin
                    if (push[i] && pop[i]) begin
                        // Old head leaves as the new word arrives, so it lands directly in the head
                        head_d[i] = bus_io.in_data;
                    end else if (push[i]) begin
                        tail_d[i]  = bus_io.in_data;
                        state_d[i] = LANE_TWO;
                    end else if (pop[i]) begin
                        state_d[i] = LANE_EMPTY;
                    end
                end
                LANE_TWO: begin
                    if (pop[i]) begin
                        head_d[i]  = tail_q[i];
                        state_d[i] = LANE_ONE;
                    end
                end
                default: state_d[i] = LANE_EMPTY;
            endcase
            valid_d[i] = (state_d[i] != LANE_EMPTY);
        end
        err_d  = accept & sel_drop;
        drop_d = (err_d && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // State registers; reset discards every buffered word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                state_q[i] <= LANE_EMPTY;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
            end
            valid_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign bus_io.in_ready   = ready;
    assign bus_io.out_valid  = valid_q;
    assign bus_io.err_sel    = err_q;
    assign bus_io.drop_count = drop_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign bus_io.out_data[g*WIDTH +: WIDTH] = head_q[g];
    end
endmodule
